// File: rtl/spi_slave.sv
// SPI slave, single system clock: 2-flop synchronised SPI inputs, edge detection on the
// synchronised SPI clock, one-byte transmit buffer and an 8-bit MSB-first shifter.
module spi_slave #(
  parameter int         MODO_SPI    = 0,
  parameter logic [7:0] DADO_OCIOSO = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_clk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  input  logic [7:0] tx_dado,
  input  logic       tx_valido,
  output logic       tx_pronto,
  output logic [7:0] rx_dado,
  output logic       rx_valido
);
  localparam logic [1:0] MODO   = MODO_SPI[1:0];
  localparam logic       CPOL   = MODO[1];
  localparam logic       CPHA   = MODO[0];
  localparam logic [0:0] OCIOSO = 1'b0;
  localparam logic [0:0] ATIVO  = 1'b1;

  logic       r_sclk_s1, r_sclk_s2, r_sclk_d;
  logic       r_cs_s1, r_cs_s2;
  logic       r_mosi_s1, r_mosi_s2;
  logic [1:0] r_warm;
  logic       r_armed;
  logic [0:0] r_estado;
  logic [2:0] r_bit;
  logic [7:0] r_tx_sr, r_rx_sr, r_buf;
  logic       r_buf_cheio, r_miso;
  logic       w_lead, w_trail, w_ativo, w_amostra, w_desloca;
  logic       w_inicio, w_fim_byte, w_consome;
  logic [7:0] w_prox;

  // Synchronisers reset to the idle bus levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_s1 <= CPOL;
      r_sclk_s2 <= CPOL;
      r_sclk_d  <= CPOL;
      r_cs_s1   <= 1'b1;
      r_cs_s2   <= 1'b1;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
      r_warm    <= 2'b00;
    end else begin
      r_sclk_s1 <= spi_clk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_d  <= r_sclk_s2;
      r_cs_s1   <= spi_cs_n;
      r_cs_s2   <= r_cs_s1;
      r_mosi_s1 <= spi_mosi;
      r_mosi_s2 <= r_mosi_s1;
      r_warm    <= {r_warm[0], 1'b1};
    end
  end

  assign w_lead     = (r_sclk_d == CPOL) && (r_sclk_s2 != CPOL);
  assign w_trail    = (r_sclk_d != CPOL) && (r_sclk_s2 == CPOL);
  assign w_ativo    = (r_estado == ATIVO) && !r_cs_s2;
  assign w_amostra  = w_ativo && (CPHA ? w_trail : w_lead);
  assign w_desloca  = w_ativo && (CPHA ? w_lead : w_trail);
  // A frame only starts after cs_n has genuinely been seen high since reset or the last frame.
  assign w_inicio   = (r_estado == OCIOSO) && r_armed && !r_cs_s2;
  assign w_fim_byte = w_amostra && (r_bit == 3'd7);
  assign w_consome  = w_inicio || w_fim_byte;
  assign w_prox     = r_buf_cheio ? r_buf : DADO_OCIOSO;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf       <= 8'h00;
      r_buf_cheio <= 1'b0;
    end else if (tx_valido && !r_buf_cheio) begin
      r_buf       <= tx_dado;
      r_buf_cheio <= 1'b1;
    end else if (w_consome) begin
      r_buf_cheio <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado  <= OCIOSO;
      r_armed   <= 1'b0;
      r_bit     <= 3'd0;
      r_tx_sr   <= 8'h00;
      r_rx_sr   <= 8'h00;
      r_miso    <= 1'b0;
      rx_dado   <= 8'h00;
      rx_valido <= 1'b0;
    end else begin
      rx_valido <= 1'b0;
      if (r_estado == OCIOSO) begin
        if (r_warm[1] && r_cs_s2) begin
          r_armed <= 1'b1;
        end else if (w_inicio) begin
          r_estado <= ATIVO;
          r_armed  <= 1'b0;
          r_bit    <= 3'd0;
          r_rx_sr  <= 8'h00;
          // With CPHA=0 the first bit must be on the line before the first clock edge.
          if (!CPHA) begin
            r_miso  <= w_prox[7];
            r_tx_sr <= {w_prox[6:0], 1'b0};
          end else begin
            r_tx_sr <= w_prox;
          end
        end
      end else if (r_cs_s2) begin
        r_estado <= OCIOSO;
        r_bit    <= 3'd0;
        r_tx_sr  <= 8'h00;
        r_rx_sr  <= 8'h00;
        r_miso   <= 1'b0;
      end else begin
        if (w_desloca) begin
          r_miso  <= r_tx_sr[7];
          r_tx_sr <= {r_tx_sr[6:0], 1'b0};
        end
        if (w_amostra) begin
          r_rx_sr <= {r_rx_sr[6:0], r_mosi_s2};
          r_bit   <= r_bit + 3'd1;
          if (w_fim_byte) begin
            rx_dado   <= {r_rx_sr[6:0], r_mosi_s2};
            rx_valido <= 1'b1;
            r_tx_sr   <= w_prox;
          end
        end
      end
    end
  end

  assign spi_miso  = r_miso;
  assign tx_pronto = !r_buf_cheio;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: one instance per SPI mode driven by a behavioural master, checked
// against a byte-level model of the transmit buffer and the received bytes.
module tb_spi_slave;
  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk      [4];
  logic       cs_n      [4];
  logic       mosi      [4];
  logic       miso      [4];
  logic [7:0] tx_dado   [4];
  logic       tx_valido [4];
  logic       tx_pronto [4];
  logic [7:0] rx_dado   [4];
  logic       rx_valido [4];

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] rxq [4][$];
  int         dbl    [4] = '{default: 0};
  logic       prev_v [4] = '{default: 1'b0};

  logic [7:0] m_buf  [4];
  logic       m_full [4];
  logic [7:0] m_cur  [4];
  logic [7:0] m_rx   [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave #(.MODO_SPI(g), .DADO_OCIOSO(g == 0 ? 8'hFF : 8'h00)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .spi_clk   (sclk[g]),
      .spi_cs_n  (cs_n[g]),
      .spi_mosi  (mosi[g]),
      .spi_miso  (miso[g]),
      .tx_dado   (tx_dado[g]),
      .tx_valido (tx_valido[g]),
      .tx_pronto (tx_pronto[g]),
      .rx_dado   (rx_dado[g]),
      .rx_valido (rx_valido[g])
    );
  end

  always @(negedge clk) begin
    for (int g = 0; g < 4; g++) begin
      if (rx_valido[g] === 1'b1) begin
        rxq[g].push_back(rx_dado[g]);
        if (prev_v[g] === 1'b1) dbl[g]++;
      end
      prev_v[g] = rx_valido[g];
    end
  end

  function automatic logic [7:0] idle_of(input int g);
    return (g == 0) ? 8'hFF : 8'h00;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkint(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input int g, input logic [7:0] b);
    int t;
    t = 0;
    while (tx_pronto[g] !== 1'b1 && t < 50) begin
      wclk(1);
      t++;
    end
    chk1("load_pronto", tx_pronto[g], 1'b1);
    chk1("load_model_empty", tx_pronto[g], ~m_full[g]);
    tx_dado[g]   = b;
    tx_valido[g] = 1'b1;
    wclk(1);
    tx_valido[g] = 1'b0;
    chk1("load_pronto_fall", tx_pronto[g], 1'b0);
    m_buf[g]  = b;
    m_full[g] = 1'b1;
  endtask

  task automatic cs_low(input int g);
    cs_n[g]   = 1'b0;
    m_cur[g]  = m_full[g] ? m_buf[g] : idle_of(g);
    m_full[g] = 1'b0;
  endtask

  task automatic cs_high(input int g, input int hp);
    wclk(hp);
    cs_n[g] = 1'b1;
    wclk(hp + 4);
  endtask

  task automatic xfer(input int g, input logic [7:0] mo, input int hp, input int nbits,
                      output logic [7:0] mi);
    logic cpol, cpha;
    cpol = g[1];
    cpha = g[0];
    mi   = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      if (!cpha) begin
        mosi[g] = mo[i];
        wclk(hp);
        sclk[g] = ~cpol;
        mi[i]   = miso[g];
        wclk(hp);
        sclk[g] = cpol;
      end else begin
        wclk(hp);
        sclk[g] = ~cpol;
        mosi[g] = mo[i];
        wclk(hp);
        sclk[g] = cpol;
        mi[i]   = miso[g];
      end
    end
  endtask

  task automatic frame(input int g, input int hp, input int nb, input logic [23:0] mo,
                       input logic mid, input logic [7:0] mid_b, input string tag);
    logic [7:0] mi, b;
    rxq[g].delete();
    cs_low(g);
    if (mid) begin
      wclk(hp + 2);
      load(g, mid_b);
    end
    for (int k = 0; k < nb; k++) begin
      b = mo[23 - 8*k -: 8];
      xfer(g, b, hp, 8, mi);
      chk({tag, "_miso"}, mi, m_cur[g]);
      m_cur[g]  = m_full[g] ? m_buf[g] : idle_of(g);
      m_full[g] = 1'b0;
      m_rx[g]   = b;
    end
    cs_high(g, hp);
    chkint({tag, "_npulse"}, rxq[g].size(), nb);
    for (int k = 0; k < nb && rxq[g].size() > 0; k++)
      chk({tag, "_rxpulse"}, rxq[g].pop_front(), mo[23 - 8*k -: 8]);
    chk({tag, "_rxdado"}, rx_dado[g], m_rx[g]);
    chk1({tag, "_pronto"}, tx_pronto[g], ~m_full[g]);
  endtask

  initial begin
    logic [7:0]  mi;
    logic [23:0] rmo;
    int          g, hp, nb;

    for (int i = 0; i < 4; i++) begin
      sclk[i]      = i[1];
      cs_n[i]      = 1'b1;
      mosi[i]      = 1'b0;
      tx_dado[i]   = 8'h00;
      tx_valido[i] = 1'b0;
      m_buf[i]     = 8'h00;
      m_full[i]    = 1'b0;
      m_cur[i]     = 8'h00;
      m_rx[i]      = 8'h00;
    end
    rst_n = 1'b0;
    wclk(2);
    for (int i = 0; i < 4; i++) begin
      chk1("rst_pronto", tx_pronto[i], 1'b1);
      chk("rst_rxdado", rx_dado[i], 8'h00);
      chk1("rst_rxvalido", rx_valido[i], 1'b0);
      chk1("rst_miso", miso[i], 1'b0);
    end
    rst_n = 1'b1;
    wclk(5);

    // Mode 0: loaded byte out, master byte in
    load(0, 8'hA5);
    frame(0, 4, 1, {8'h3C, 16'h0}, 1'b0, 8'h00, "m0_a5");

    // Mode 3
    load(3, 8'h81);
    frame(3, 4, 1, {8'hC3, 16'h0}, 1'b0, 8'h00, "m3_81");

    // Mode 1: two bytes in one frame, a write while full is ignored
    load(1, 8'h12);
    tx_dado[1]   = 8'hEE;
    tx_valido[1] = 1'b1;
    wclk(1);
    tx_valido[1] = 1'b0;
    chk1("m1_ignored_pronto", tx_pronto[1], 1'b0);
    frame(1, 4, 2, {8'hF0, 8'h0F, 8'h00}, 1'b1, 8'h34, "m1_two");

    // Mode 0 with nothing loaded: idle byte, buffer stays empty
    frame(0, 4, 1, {8'hC4, 16'h0}, 1'b0, 8'h00, "m0_idle");
    chk1("m0_idle_pronto_hold", tx_pronto[0], 1'b1);

    // Mode 2: aborted partial byte, buffered byte survives the abort
    frame(2, 5, 1, {8'hA7, 16'h0}, 1'b0, 8'h00, "m2_pre");
    rxq[2].delete();
    cs_low(2);
    wclk(6);
    load(2, 8'hC8);
    xfer(2, 8'h6D, 4, 5, mi);
    cs_high(2, 4);
    chkint("m2_part_npulse", rxq[2].size(), 0);
    chk("m2_part_rxdado", rx_dado[2], m_rx[2]);
    chk1("m2_part_pronto", tx_pronto[2], 1'b0);
    frame(2, 4, 1, {8'h5A, 16'h0}, 1'b0, 8'h00, "m2_5a");

    // Reset mid-byte, then stray clocks with cs_n still low, then a clean frame
    load(0, 8'h7E);
    rxq[0].delete();
    cs_low(0);
    xfer(0, 8'hE1, 4, 4, mi);
    load(0, 8'h66);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk1("midrst_pronto", tx_pronto[i], 1'b1);
      chk("midrst_rxdado", rx_dado[i], 8'h00);
      chk1("midrst_rxvalido", rx_valido[i], 1'b0);
      chk1("midrst_miso", miso[i], 1'b0);
      m_full[i] = 1'b0;
      m_rx[i]   = 8'h00;
    end
    wclk(3);
    rst_n = 1'b1;
    wclk(4);
    xfer(0, 8'hB4, 4, 8, mi);
    wclk(8);
    chkint("midrst_stray_npulse", rxq[0].size(), 0);
    chk("midrst_stray_rxdado", rx_dado[0], 8'h00);
    cs_n[0] = 1'b1;
    wclk(8);
    load(0, 8'h3D);
    frame(0, 4, 1, {8'h99, 16'h0}, 1'b0, 8'h00, "midrst_99");

    // Randomised frames across all modes
    for (int it = 0; it < 10; it++) begin
      g   = $urandom_range(3, 0);
      hp  = $urandom_range(7, 4);
      nb  = $urandom_range(3, 1);
      rmo = 24'($urandom());
      if ($urandom_range(1, 0) == 1) load(g, 8'($urandom()));
      frame(g, hp, nb, rmo, 1'($urandom_range(1, 0)), 8'($urandom()), "rnd");
    end

    for (int i = 0; i < 4; i++) chkint("single_cycle_pulse", dbl[i], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
